// File: rtl/snn_pkg.sv
// Shared types and default widths for the spiking-network motor driver.
package snn_pkg;

   localparam int CNT_W_DEF = 10;
   localparam int PWM_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCALE = 2'd1,
      STALE = 2'd2
   } snn_state_e;

endpackage

// File: rtl/snn_motor_driver_pwm_channel.sv
// One motor channel: slew-limited duty register updated only on the PWM wrap,
// plus the duty comparator that produces the PWM output.
module pwm_channel
   import snn_pkg::*;
#(
   parameter int PWM_W = PWM_W_DEF,
   parameter int SLEW  = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             wrap_i,
   input  logic [PWM_W-1:0] pwm_cnt_i,
   input  logic [PWM_W-1:0] target_i,
   output logic [PWM_W-1:0] duty_o,
   output logic             pwm_o
);

   localparam logic [PWM_W:0]   SLEW_WIDE = (PWM_W+1)'(SLEW);
   localparam logic [PWM_W-1:0] SLEW_STEP = PWM_W'(SLEW);

   logic [PWM_W-1:0] duty_q, duty_d;
   logic [PWM_W:0]   diff_up, diff_dn;

   // Differences are one bit wider so the magnitude test cannot wrap.
   always_comb begin
      diff_up = {1'b0, target_i} - {1'b0, duty_q};
      diff_dn = {1'b0, duty_q} - {1'b0, target_i};
      duty_d  = duty_q;
      if (wrap_i) begin
         if (target_i >= duty_q) begin
            duty_d = (diff_up <= SLEW_WIDE) ? target_i : duty_q + SLEW_STEP;
         end else begin
            duty_d = (diff_dn <= SLEW_WIDE) ? target_i : duty_q - SLEW_STEP;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) duty_q <= '0;
      else         duty_q <= duty_d;
   end

   assign duty_o = duty_q;
   assign pwm_o  = en_i && (pwm_cnt_i < duty_q);

endmodule

// File: rtl/snn_motor_driver.sv
// Converts left/right spike-count windows into two slew-limited PWM drives;
// a sample_tick watchdog forces both targets to zero when windows stop arriving.
module snn_motor_driver
   import snn_pkg::*;
#(
   parameter int CNT_W         = CNT_W_DEF,
   parameter int PWM_W         = PWM_W_DEF,
   parameter int CNT_SHIFT     = 2,
   parameter int SLEW          = 8,
   parameter int TIMEOUT_TICKS = 2000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sample_tick,
   input  logic             cnt_valid,
   output logic             cnt_ready,
   input  logic [CNT_W-1:0] cnt_left,
   input  logic [CNT_W-1:0] cnt_right,
   output logic             pwm_left,
   output logic             pwm_right,
   output logic [PWM_W-1:0] duty_left,
   output logic [PWM_W-1:0] duty_right,
   output logic             stale,
   output snn_state_e       fsm_state
);

   localparam int               WD_W     = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_TICKS);
   localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'((1 << PWM_W) - 1);

   // Handshake: a pair is taken on any rising edge where cnt_valid && cnt_ready.
   // cnt_ready is low while scaling and whenever en is low.

   snn_state_e       state_q, state_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [CNT_W-1:0] cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
   logic [PWM_W-1:0] tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
   logic             accept, expired, wrap;

   function automatic logic [PWM_W-1:0] to_target(input logic [CNT_W-1:0] c);
      logic [CNT_W-1:0] s;
      s = c >> CNT_SHIFT;
      return (s > DUTY_MAX) ? {PWM_W{1'b1}} : s[PWM_W-1:0];
   endfunction

   assign cnt_ready = en && (state_q != SCALE);
   assign accept    = cnt_valid && cnt_ready;
   assign expired   = (wd_q == WD_MAX);
   assign wrap      = en && (pwm_cnt_q == '1);
   assign stale     = expired;
   assign fsm_state = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Acceptance takes priority over the watchdog expiring in the same cycle.
   always_comb begin
      state_d = state_q;
      if (en) begin
         case (state_q)
            IDLE:    if (cnt_valid) state_d = SCALE;
                     else if (expired) state_d = STALE;
            SCALE:   state_d = IDLE;
            STALE:   if (cnt_valid) state_d = SCALE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      pwm_cnt_d = pwm_cnt_q;
      wd_d      = wd_q;
      cnt_l_d   = cnt_l_q;
      cnt_r_d   = cnt_r_q;
      tgt_l_d   = tgt_l_q;
      tgt_r_d   = tgt_r_q;
      if (en) begin
         pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
         if (accept) begin
            cnt_l_d = cnt_left;
            cnt_r_d = cnt_right;
         end
         if (state_q == SCALE) begin
            tgt_l_d = to_target(cnt_l_q);
            tgt_r_d = to_target(cnt_r_q);
         end else if (state_d == STALE) begin
            tgt_l_d = '0;
            tgt_r_d = '0;
         end
         if (accept || state_q == SCALE) wd_d = '0;
         else if (sample_tick && !expired) wd_d = wd_q + WD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_cnt_q <= '0;
         wd_q      <= '0;
         cnt_l_q   <= '0;
         cnt_r_q   <= '0;
         tgt_l_q   <= '0;
         tgt_r_q   <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         wd_q      <= wd_d;
         cnt_l_q   <= cnt_l_d;
         cnt_r_q   <= cnt_r_d;
         tgt_l_q   <= tgt_l_d;
         tgt_r_q   <= tgt_r_d;
      end
   end

   pwm_channel #(.PWM_W(PWM_W), .SLEW(SLEW)) u_left (
      .clk_i     (clk),
      .rst_ni    (rst),
      .en_i      (en),
      .wrap_i    (wrap),
      .pwm_cnt_i (pwm_cnt_q),
      .target_i  (tgt_l_q),
      .duty_o    (duty_left),
      .pwm_o     (pwm_left)
   );

   pwm_channel #(.PWM_W(PWM_W), .SLEW(SLEW)) u_right (
      .clk_i     (clk),
      .rst_ni    (rst),
      .en_i      (en),
      .wrap_i    (wrap),
      .pwm_cnt_i (pwm_cnt_q),
      .target_i  (tgt_r_q),
      .duty_o    (duty_right),
      .pwm_o     (pwm_right)
   );

endmodule

// File: tb/tb_snn_motor_driver.sv
// Bench for snn_motor_driver: cycle reference model of the window/slew/watchdog
// rules, a target table, and directed sequences for the multi-cycle corners.
module tb_snn_motor_driver;
   import snn_pkg::*;

   localparam int CNT_W     = 10;
   localparam int PWM_W     = 8;
   localparam int CNT_SHIFT = 2;
   localparam int SLEW      = 8;
   localparam int TIMEOUT   = 2000;
   localparam int PMAX      = 255;
   localparam int PERIOD    = 256;

   logic             clk = 1'b0;
   logic             rst, en, sample_tick, cnt_valid;
   logic             cnt_ready, pwm_left, pwm_right, stale;
   logic [CNT_W-1:0] cnt_left, cnt_right;
   logic [PWM_W-1:0] duty_left, duty_right;
   snn_state_e       fsm_state;

   always #5 clk = ~clk;

   snn_motor_driver #(
      .CNT_W(CNT_W), .PWM_W(PWM_W), .CNT_SHIFT(CNT_SHIFT),
      .SLEW(SLEW), .TIMEOUT_TICKS(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .sample_tick(sample_tick),
      .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
      .cnt_left(cnt_left), .cnt_right(cnt_right),
      .pwm_left(pwm_left), .pwm_right(pwm_right),
      .duty_left(duty_left), .duty_right(duty_right),
      .stale(stale), .fsm_state(fsm_state)
   );

   int checks = 0;
   int passed = 0;
   int fails_shown = 0;

   // Reference model: plain integers, no notion of the RTL state encoding.
   int m_cnt, m_wd;
   int m_duty[2], m_tgt[2], m_lat[2];
   bit m_busy, m_wrap;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else begin
         if (fails_shown < 40)
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
         fails_shown++;
      end
   endtask

   function automatic int target_of(input int c);
      int s;
      s = c >> CNT_SHIFT;
      return (s > PMAX) ? PMAX : s;
   endfunction

   function automatic int slew_to(input int d, input int t);
      if (t >= d) return (t - d <= SLEW) ? t : d + SLEW;
      else        return (d - t <= SLEW) ? t : d - SLEW;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_wd = 0; m_busy = 0; m_wrap = 0;
      for (int i = 0; i < 2; i++) begin
         m_duty[i] = 0; m_tgt[i] = 0; m_lat[i] = 0;
      end
   endtask

   // Drive one cycle, compare outputs mid-cycle, advance the model at the edge.
   task automatic step(input bit e, input bit v, input bit t, input int cl, input int cr);
      bit rdy;
      en = e; cnt_valid = v; sample_tick = t;
      cnt_left = CNT_W'(cl); cnt_right = CNT_W'(cr);
      @(negedge clk);
      rdy = e && !m_busy;
      check("cnt_ready", cnt_ready, rdy);
      check("stale", stale, m_wd == TIMEOUT);
      check("pwm_left", pwm_left, e && (m_cnt < m_duty[0]));
      check("pwm_right", pwm_right, e && (m_cnt < m_duty[1]));
      check("duty_left", duty_left, m_duty[0]);
      check("duty_right", duty_right, m_duty[1]);
      m_wrap = 0;
      if (e) begin
         m_wrap = (m_cnt == PMAX);
         if (m_wrap)
            for (int i = 0; i < 2; i++) m_duty[i] = slew_to(m_duty[i], m_tgt[i]);
         if (m_busy) begin
            for (int i = 0; i < 2; i++) m_tgt[i] = target_of(m_lat[i]);
            m_busy = 0; m_wd = 0;
         end else if (v && rdy) begin
            m_lat[0] = cl; m_lat[1] = cr; m_busy = 1; m_wd = 0;
         end else begin
            if (m_wd == TIMEOUT)
               for (int i = 0; i < 2; i++) m_tgt[i] = 0;
            if (t && m_wd < TIMEOUT) m_wd++;
         end
         m_cnt = (m_cnt + 1) % PERIOD;
      end
      @(posedge clk); #1;
   endtask

   task automatic send(input int cl, input int cr);
      step(1, 1, 0, cl, cr);
      step(1, 0, 0, 0, 0);
   endtask

   task automatic run_periods(input int n, input bit t);
      repeat (n * PERIOD) step(1, 0, t, 0, 0);
   endtask

   task automatic wait_wrap();
      int k;
      k = 0;
      m_wrap = 0;
      while (!m_wrap && k < PERIOD + 1) begin
         step(1, 0, 0, 0, 0);
         k++;
      end
      if (!m_wrap) check("wrap_timeout", 0, 1);
   endtask

   task automatic random_phase(input int ncyc, input int valid_div, input int tick_div);
      repeat (ncyc)
         step($urandom_range(0, 9) != 0, $urandom_range(0, valid_div - 1) == 0,
              $urandom_range(0, tick_div - 1) == 0,
              $urandom_range(0, 1023), $urandom_range(0, 1023));
   endtask

   typedef struct {
      int cl;
      int cr;
      int exp_l;
      int exp_r;
   } vec_t;

   initial begin
      vec_t tbl[5];
      int   prev_l, prev_r, diff, hi_l, hi_r, dl, dr;

      tbl[0] = '{200, 200, 50, 50};
      tbl[1] = '{3, 7, 0, 1};
      tbl[2] = '{4, 16, 1, 4};
      tbl[3] = '{1019, 1023, 254, 255};
      tbl[4] = '{1023, 1020, 255, 255};

      // Reset values, observed while reset is still asserted.
      rst = 1'b0; en = 1'b1; sample_tick = 1'b0; cnt_valid = 1'b0;
      cnt_left = '0; cnt_right = '0;
      model_reset();
      #2;
      check("rst_duty_left", duty_left, 0);
      check("rst_duty_right", duty_right, 0);
      check("rst_pwm_left", pwm_left, 0);
      check("rst_pwm_right", pwm_right, 0);
      check("rst_cnt_ready", cnt_ready, 1);
      check("rst_stale", stale, 0);
      check("rst_state", fsm_state, IDLE);
      @(posedge clk); #1;
      rst = 1'b1;

      // Basic ramp: 400 -> target 100, left steps by 8 then lands on 100.
      send(400, 0);
      for (int k = 0; k < 13; k++) begin
         wait_wrap();
         check("ramp_left", duty_left, (k < 12) ? 8 * (k + 1) : 100);
         check("ramp_right", duty_right, 0);
      end

      // Target table: each row settles after enough whole periods.
      prev_l = 100; prev_r = 0;
      for (int r = 0; r < 5; r++) begin
         diff = (tbl[r].exp_l > prev_l) ? tbl[r].exp_l - prev_l : prev_l - tbl[r].exp_l;
         if (tbl[r].exp_r > prev_r && tbl[r].exp_r - prev_r > diff) diff = tbl[r].exp_r - prev_r;
         if (prev_r > tbl[r].exp_r && prev_r - tbl[r].exp_r > diff) diff = prev_r - tbl[r].exp_r;
         send(tbl[r].cl, tbl[r].cr);
         run_periods((diff + SLEW - 1) / SLEW + 2, 0);
         check("table_duty_left", duty_left, tbl[r].exp_l);
         check("table_duty_right", duty_right, tbl[r].exp_r);
         prev_l = tbl[r].exp_l; prev_r = tbl[r].exp_r;
      end

      // Saturation: full duty is high 255 of 256 cycles, then ramps down by 8.
      hi_l = 0; hi_r = 0;
      repeat (PERIOD) begin
         step(1, 0, 0, 0, 0);
         hi_l += int'(pwm_left);
         hi_r += int'(pwm_right);
      end
      check("sat_high_left", hi_l, 255);
      check("sat_high_right", hi_r, 255);
      send(0, 0);
      for (int k = 0; k < 32; k++) begin
         wait_wrap();
         check("rampdown_left", duty_left, (255 - 8 * (k + 1) > 0) ? 255 - 8 * (k + 1) : 0);
      end
      check("rampdown_right_end", duty_right, 0);

      // Enable freeze mid-period.
      send(400, 400);
      run_periods(2, 0);
      repeat (100) step(1, 0, 0, 0, 0);
      dl = duty_left; dr = duty_right;
      repeat (30) begin
         step(0, 1, 1, 900, 900);
         check("freeze_pwm_left", pwm_left, 0);
         check("freeze_pwm_right", pwm_right, 0);
         check("freeze_duty_left", duty_left, dl);
         check("freeze_duty_right", duty_right, dr);
         check("freeze_ready", cnt_ready, 0);
      end
      repeat (300) step(1, 0, 0, 0, 0);

      // Watchdog: 2000 ticks with no window.
      repeat (TIMEOUT - 1) step(1, 0, 1, 0, 0);
      check("wd_before", stale, 0);
      step(1, 0, 1, 0, 0);
      check("wd_stale", stale, 1);
      step(1, 0, 1, 0, 0);
      check("wd_state", fsm_state, STALE);
      run_periods(15, 1);
      check("wd_duty_left", duty_left, 0);
      check("wd_duty_right", duty_right, 0);
      check("wd_hold", stale, 1);
      send(200, 200);
      check("wd_clear", stale, 0);
      run_periods(9, 0);
      check("wd_recover_left", duty_left, 50);
      check("wd_recover_right", duty_right, 50);

      // Collision: acceptance on the cycle of the 2000th tick wins.
      repeat (TIMEOUT - 1) step(1, 0, 1, 0, 0);
      step(1, 1, 1, 60, 80);
      check("coll_stale0", stale, 0);
      step(1, 0, 1, 0, 0);
      check("coll_stale1", stale, 0);
      check("coll_state", fsm_state != STALE, 1);
      run_periods(8, 0);
      check("coll_left", duty_left, 15);
      check("coll_right", duty_right, 20);

      // Async reset during scaling: duties clear without an edge, pair discarded.
      step(1, 1, 0, 1023, 1023);
      rst = 1'b0;
      #1;
      check("arst_duty_left", duty_left, 0);
      check("arst_duty_right", duty_right, 0);
      check("arst_pwm_left", pwm_left, 0);
      check("arst_pwm_right", pwm_right, 0);
      model_reset();
      #1 rst = 1'b1;
      step(1, 0, 0, 0, 0);
      check("arst_ready", cnt_ready, 1);
      run_periods(2, 0);
      check("arst_discard_left", duty_left, 0);
      check("arst_discard_right", duty_right, 0);

      // Random traffic, then sparse windows with dense ticks to reach stale.
      random_phase(3000, 8, 4);
      random_phase(5000, 1500, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
